serie_exchange_sequencer: RTL

Sequencer that drives the serial-in/serial-out shift register (Data_In, Ena, LeRi, Data_Out) as a word-level exchange engine. On each accepted request it shifts a parallel word into the register bit by bit, in the requested direction. In the same shift cycles it reassembles the word that the register previously held from the serial output. It sits between a parallel requester and the serial register and owns the register's Ena and LeRi lines.

---
 rtl/serie_exchange_sequencer_if.sv | 23 ++
 rtl/serie_exchange_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serie_exchange_sequencer_if.sv
// Request-side bus of the serial exchange sequencer: word request handshake and exchange result.
interface serie_exchange_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             Start;
   logic             Dir;
   logic [WIDTH-1:0] Word_In;
   logic             Ready;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Word_Out;
   logic             Par_Out;

   modport master (
      output Start, Dir, Word_In,
      input  Ready, Busy, Done, Word_Out, Par_Out
   );

   modport slave (
      input  Start, Dir, Word_In,
      output Ready, Busy, Done, Word_Out, Par_Out
   );
endinterface

// File: rtl/serie_exchange_sequencer.sv
// Word-level exchange engine for a SISO shift register: loads a word serially while capturing the old contents.
// Optional feature macro: SERIE_SEQ_PARITY_EN (even parity of Word_Out on Par_Out).
module serie_exchange_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic                       Clk,
   input  logic                       Rst,
   serie_exchange_sequencer_if.slave  req,
   output logic                       Sr_Data_In,
   output logic                       Sr_Ena,
   output logic                       Sr_LeRi,
   input  logic                       Sr_Data_Out
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] word_out_q, word_out_d;
   logic             leri_q, leri_d;
   logic             shifting;
   logic             accept;
   logic             last;

   assign shifting = (state_q == S_SHIFT);
   assign accept   = !shifting && req.Start;
   assign last     = (cnt_q == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = req.Start ? S_SHIFT : S_IDLE;
         S_SHIFT:        state_d = last ? S_DONE : S_SHIFT;
         default:        state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      req.Ready  = !shifting;
      req.Busy   = shifting;
      req.Done   = (state_q == S_DONE);
      Sr_Ena     = shifting;
      Sr_LeRi    = leri_q;
      Sr_Data_In = 1'b0;
      if (shifting) Sr_Data_In = leri_q ? word_q[WIDTH-1] : word_q[0];
   end

   // The load word is shifted in place so the outgoing bit always sits at a fixed end.
   always_comb begin
      cnt_d      = cnt_q;
      word_d     = word_q;
      cap_d      = cap_q;
      word_out_d = word_out_q;
      leri_d     = leri_q;
      if (accept) begin
         word_d = req.Word_In;
         leri_d = req.Dir;
         cnt_d  = '0;
      end else if (shifting) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (leri_q) begin
            word_d = {word_q[WIDTH-2:0], 1'b0};
            cap_d  = {cap_q[WIDTH-2:0], Sr_Data_Out};
         end else begin
            word_d = {1'b0, word_q[WIDTH-1:1]};
            cap_d  = {Sr_Data_Out, cap_q[WIDTH-1:1]};
         end
         if (last) word_out_d = cap_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q      <= '0;
         word_out_q <= '0;
         leri_q     <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         word_out_q <= word_out_d;
         leri_q     <= leri_d;
      end
   end

   // Datapath shift registers need no reset: they are reloaded on every acceptance.
   always_ff @(posedge Clk) begin
      word_q <= word_d;
      cap_q  <= cap_d;
   end

   assign req.Word_Out = word_out_q;

`ifdef SERIE_SEQ_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (!accept && shifting && last) par_d = even_parity(cap_d);
   end

   always_ff @(posedge Clk) begin
      if (Rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end

   assign req.Par_Out = par_q;
`else
   assign req.Par_Out = 1'b0;
`endif

endmodule
